data_mem: RTL and testbench
===========================

# data_mem

Byte-addressed data memory responder: the target end of the CPU load/store interface (address, store data, size code, write strobe, returned load data). Accepts one request at a time via a ready/request handshake, performs sized byte-lane writes and right-justified reads, and splits accesses that straddle a word boundary into two word cycles. Sign/zero extension stays in the CPU; this block returns raw right-justified bytes.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
- INIT_FILE, "", hex file loaded into the array at elaboration; empty means contents undefined
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_req  input  1  request valid; accepted on a rising edge where i_req && o_ready
- o_ready  output  1  block idle, can accept a request
- i_write  input  1  1 = store, 0 = load
- i_addr  input  32  byte address
- i_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- i_memsize  input  2  00 none, 01 byte, 10 half, 11 word (CPU encoding)
- o_done  output  1  one-cycle completion pulse for every accepted request
- o_rdata  output  32  load data, right-justified, bytes above size zero; valid when o_done && load
- o_fault  output  1  out-of-range access; valid with o_done

## Operation
- States: IDLE, LO, HI, RESP. o_ready = 1 only in IDLE.
- Accept in IDLE: capture write, addr, wdata, size; off = addr[1:0], n = bytes (0/1/2/4), w0 = addr[31:2], cross = (off + n > 4).
- Range check at accept: fault if w0 >= DEPTH_WORDS, or cross and w0+1 >= DEPTH_WORDS (no wrap to word 0). Faulted or size 00 requests: IDLE -> RESP directly, no array access, o_rdata = 0.
- Lane mask: 7-bit m = ((1<<n)-1) << off; m[3:0] lanes of word w0, m[6:4] lanes [2:0] of word w0+1.
- Store data: 64-bit d = {32'b0, wdata} << (8*off); low half to w0 lanes, high half to w0+1 lanes. Unmasked lanes unchanged.
- LO: access w0 (write masked lanes or latch read word). Then HI if cross, else RESP.
- HI: access w0+1. Then RESP.
- Load result: ({hi_word, lo_word} >> 8*off)[31:0] masked to n bytes (hi_word = 0 if not cross).
- RESP: o_done = 1, o_fault/o_rdata driven from captured result; -> IDLE.
- Stores: o_rdata = 0 on completion.

## Timing
- Reset values: o_ready 0, o_done 0, o_fault 0, o_rdata 0, state IDLE. o_ready rises the cycle after first edge with i_rst_n = 1.
- Request accepted edge E. Aligned: o_done high in the cycle after edge E+2. Crossing: after edge E+3. Fault/size 00: after edge E+1.
- Next acceptance earliest in the cycle after RESP; inputs other than i_req ignored when o_ready = 0.
- Reset asserted mid-operation: request dropped, no o_done; a write whose LO edge completed but HI did not leaves low half committed (defined, not an error). Reset edge itself performs no array write.
- Read of a word written by the previous request returns new data (array write precedes any later read edge).

## Structure
- Package mem_pkg: memsize enum (MEM_NONE 2'b00, MEM_B 2'b01, MEM_H 2'b10, MEM_W 2'b11), state enum, function bytes_of(memsize). CPU store-size logic imports the same enum.
- Sub-module mem_lane_align (combinational): off, size, wdata, lo/hi read words -> 7-bit mask, 64-bit shifted store data, right-justified masked load data.
- Array: single-port, one access per cycle; inferred RAM, no reset on contents.

## Test plan
- Word store 0xDEADBEEF @0x10, word load @0x10 -> o_rdata 0xDEADBEEF, o_done 2 cycles after accept, o_fault 0.
- Byte store 0xAB @0x13 over 0x11223344, word load @0x10 -> 0xAB223344; byte load @0x13 -> 0x000000AB.
- Half store 0xCAFE @0x17 (crossing) over words 0 at 0x14/0x18 -> word 0x14 = 0xFE000000, word 0x18 = 0x000000CA; half load @0x17 -> 0x0000CAFE, o_done 3 cycles after accept.
- Word store @4*DEPTH_WORDS-2 -> o_fault 1 one cycle after accept, last word unchanged; word load @4*DEPTH_WORDS -> o_fault 1, o_rdata 0.
- Size 00 request -> o_done after 1 cycle, no memory change; i_req held high during busy -> exactly one acceptance per o_done.
- Reset asserted in HI of a crossing word store @0x1E -> no o_done, o_ready 0 then 1 after release, low word bytes written, high word unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the CPU load/store interface and the data memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_B    = 2'b01,
    MEM_H    = 2'b10,
    MEM_W    = 2'b11
  } memsize_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic [2:0] bytes_of(memsize_e size);
    case (size)
      MEM_B:   bytes_of = 3'd1;
      MEM_H:   bytes_of = 3'd2;
      MEM_W:   bytes_of = 3'd4;
      default: bytes_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: lane mask, store data shifted into position, and
// right-justified load data taken from a pair of words.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  memsize_e    size,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [6:0]  mask,
  output logic [63:0] wdata_sh,
  output logic [31:0] rdata
);

  logic [2:0]  n;
  logic [6:0]  base;
  logic [31:0] byte_mask;
  logic [63:0] rd_sh;

  always_comb begin
    n         = bytes_of(size);
    base      = 7'((8'd1 << n) - 8'd1);
    mask      = base << off;
    wdata_sh  = {32'b0, wdata} << {off, 3'b000};
    rd_sh     = {hi_word, lo_word} >> {off, 3'b000};
    byte_mask = '0;
    for (int i = 0; i < 4; i++) begin
      byte_mask[8*i +: 8] = {8{base[i]}};
    end
    rdata = rd_sh[31:0] & byte_mask;
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed data memory responder with sized accesses; word-straddling
// accesses are split into two single-port array cycles.
module data_mem
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  output logic        o_ready,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_memsize,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic        ready_q, done_q, rfault_q;
  logic [31:0] rdata_q;
  logic        write_q, cross_q, fault_q;
  logic [1:0]  off_q;
  memsize_e    size_q;
  logic [31:0] wdata_q, lo_q, hi_q;
  logic [29:0] w0_q;

  logic        accept, cross_in, fault_in;
  logic [2:0]  n_in;
  logic [29:0] w0_in, acc_word;
  logic [AW-1:0] idx;
  logic        unused_acc;
  logic [6:0]  mask;
  logic [63:0] wdata_sh;
  logic [31:0] align_rdata, rdata_res, wr_word;
  logic [3:0]  we_lanes;

  assign accept   = i_req && ready_q;
  assign n_in     = bytes_of(memsize_e'(i_memsize));
  assign w0_in    = i_addr[31:2];
  assign cross_in = ({2'b00, i_addr[1:0]} + {1'b0, n_in}) > 4'd4;
  // No wrap: a straddle off the last word faults rather than touching word 0.
  assign fault_in = ({2'b00, w0_in} >= DEPTH_WORDS) ||
                    (cross_in && (({2'b00, w0_in} + 32'd1) >= DEPTH_WORDS));

  mem_lane_align u_align (
    .off      (off_q),
    .size     (size_q),
    .wdata    (wdata_q),
    .lo_word  (lo_q),
    .hi_word  (hi_q),
    .mask     (mask),
    .wdata_sh (wdata_sh),
    .rdata    (align_rdata)
  );

  assign acc_word   = (state_q == ST_HI) ? (w0_q + 30'd1) : w0_q;
  assign idx        = acc_word[AW-1:0];
  assign unused_acc = ^acc_word;
  assign we_lanes   = (state_q == ST_LO) ? mask[3:0] : {1'b0, mask[6:4]};
  assign wr_word    = (state_q == ST_LO) ? wdata_sh[31:0] : wdata_sh[63:32];
  assign rdata_res  = (!write_q && !fault_q && size_q != MEM_NONE) ? align_rdata : 32'd0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (fault_in || n_in == 3'd0) ? ST_RESP : ST_LO;
      ST_LO:   state_d = cross_q ? ST_HI : ST_RESP;
      ST_HI:   state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Array port: contents never reset, and a reset edge performs no write.
  always_ff @(posedge i_clk) begin
    if (accept) hi_q <= '0;
    if (i_rst_n && (state_q == ST_LO || state_q == ST_HI)) begin
      if (write_q) begin
        for (int b = 0; b < 4; b++) begin
          if (we_lanes[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
      end else if (state_q == ST_LO) begin
        lo_q <= mem[idx];
      end else begin
        hi_q <= mem[idx];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      rfault_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      done_q  <= (state_q == ST_RESP);
      if (state_q == ST_RESP) begin
        rfault_q <= fault_q;
        rdata_q  <= rdata_res;
      end
      if (accept) begin
        write_q <= i_write;
        off_q   <= i_addr[1:0];
        size_q  <= memsize_e'(i_memsize);
        wdata_q <= i_wdata;
        w0_q    <= w0_in;
        cross_q <= cross_in;
        fault_q <= fault_in;
      end
    end
  end

  assign o_ready = ready_q;
  assign o_done  = done_q;
  assign o_fault = rfault_q;
  assign o_rdata = rdata_q;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem against a byte-array reference model.
module tb_data_mem;

  localparam int unsigned D = 64;

  logic        clk = 1'b0;
  logic        rst_n, req, ready, write, done, fault;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  memsize;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [4*D];

  data_mem #(.DEPTH_WORDS(D), .INIT_FILE("")) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .o_ready   (ready),
    .i_write   (write),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .i_memsize (memsize),
    .o_done    (done),
    .o_rdata   (rdata),
    .o_fault   (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-granular memory, bounds from the last byte touched.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, output logic [31:0] rd, output logic flt,
                       output int lat);
    int n;
    longint last;
    n    = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : (sz == 2'd3) ? 4 : 0;
    last = longint'(a) + ((n == 0) ? 0 : n - 1);
    flt  = (last >= 4*D);
    rd   = '0;
    if (flt || n == 0) lat = 1;
    else if (int'(a % 4) + n > 4) lat = 3;
    else lat = 2;
    if (!flt) begin
      for (int i = 0; i < n; i++) begin
        if (w) ref_mem[a + i] = d[8*i +: 8];
        else rd[8*i +: 8] = ref_mem[a + i];
      end
    end
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, output logic [31:0] rd, output logic flt,
                      output int lat);
    int waited = 0;
    @(negedge clk);
    while (!ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) chk("ready_wait", {31'b0, ready}, 32'd1);
    write = w; addr = a; wdata = d; memsize = sz; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    write = $urandom; addr = $urandom; wdata = $urandom; memsize = 2'($urandom);
    lat = -1; rd = 'x; flt = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k; rd = rdata; flt = fault;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] sz, output logic [31:0] rd);
    logic [31:0] erd;
    logic        eflt, flt;
    int          elat, lat;
    model(w, a, d, sz, erd, eflt, elat);
    xact(w, a, d, sz, rd, flt, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_fault"}, {31'b0, flt}, {31'b0, eflt});
    chk({tag, "_rdata"}, rd, erd);
  endtask

  initial begin
    logic [31:0] rd, erd;
    logic        eflt;
    int          elat, acc, dn;

    rst_n = 1'b0; req = 1'b0; write = 1'b0; addr = '0; wdata = '0; memsize = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_done",  {31'b0, done},  32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_before_edge", {31'b0, ready}, 32'd0);
    @(posedge clk);
    #1 chk("ready_after_edge", {31'b0, ready}, 32'd1);

    for (int i = 0; i < int'(D); i++) begin
      model(1'b1, 32'(4*i), 32'd0, 2'd3, erd, eflt, elat);
      xact(1'b1, 32'(4*i), 32'd0, 2'd3, rd, eflt, elat);
    end

    run("w_store", 1'b1, 32'h10, 32'hDEADBEEF, 2'd3, rd);
    run("w_load",  1'b0, 32'h10, 32'h0, 2'd3, rd);
    chk("w_load_const", rd, 32'hDEADBEEF);
    run("w_store2", 1'b1, 32'h10, 32'h11223344, 2'd3, rd);
    run("b_store", 1'b1, 32'h13, 32'h000000AB, 2'd1, rd);
    run("w_load2", 1'b0, 32'h10, 32'h0, 2'd3, rd);
    chk("w_load2_const", rd, 32'hAB223344);
    run("b_load", 1'b0, 32'h13, 32'h0, 2'd1, rd);
    chk("b_load_const", rd, 32'h000000AB);
    run("h_store_x", 1'b1, 32'h17, 32'h0000CAFE, 2'd2, rd);
    run("w14_load", 1'b0, 32'h14, 32'h0, 2'd3, rd);
    chk("w14_const", rd, 32'hFE000000);
    run("w18_load", 1'b0, 32'h18, 32'h0, 2'd3, rd);
    chk("w18_const", rd, 32'h000000CA);
    run("h_load_x", 1'b0, 32'h17, 32'h0, 2'd2, rd);
    chk("h_load_x_const", rd, 32'h0000CAFE);
    run("fault_store", 1'b1, 32'(4*D - 2), 32'h12345678, 2'd3, rd);
    run("last_word", 1'b0, 32'(4*D - 4), 32'h0, 2'd3, rd);
    chk("last_word_const", rd, 32'h0);
    run("fault_load", 1'b0, 32'(4*D), 32'h0, 2'd3, rd);
    run("none_req", 1'b1, 32'h10, 32'hFFFFFFFF, 2'd0, rd);
    run("after_none", 1'b0, 32'h10, 32'h0, 2'd3, rd);

    // Request held high: one acceptance per completion, every 3 cycles.
    model(1'b0, 32'h10, 32'h0, 2'd3, erd, eflt, elat);
    acc = 0; dn = 0;
    @(negedge clk);
    write = 1'b0; addr = 32'h10; memsize = 2'd3; req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (ready && req) acc++;
      @(posedge clk);
      #1;
      if (done) begin
        dn++;
        chk("held_rdata", rdata, erd);
      end
      @(negedge clk);
    end
    req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 if (done) dn++;
    end
    chk("held_accepts", 32'(acc), 32'd10);
    chk("held_dones", 32'(dn), 32'(acc));

    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4*D + 7));
      run("rand", 1'($urandom), a, $urandom, 2'($urandom), rd);
    end

    // Reset while a crossing word store is in its HI cycle.
    run("pre1c", 1'b1, 32'h1C, 32'hA1A2A3A4, 2'd3, rd);
    run("pre20", 1'b1, 32'h20, 32'hB1B2B3B4, 2'd3, rd);
    ref_mem[32'h1E] = 8'h88;
    ref_mem[32'h1F] = 8'h77;
    @(negedge clk);
    write = 1'b1; addr = 32'h1E; wdata = 32'h55667788; memsize = 2'd3; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk("rst_hi_done", {31'b0, done}, 32'd0);
      chk("rst_hi_ready", {31'b0, ready}, 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_hi_ready_low", {31'b0, ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hi_ready_up", {31'b0, ready}, 32'd1);
    chk("rst_hi_no_done", {31'b0, done}, 32'd0);
    run("post1c", 1'b0, 32'h1C, 32'h0, 2'd3, rd);
    chk("post1c_const", rd, 32'h7788A3A4);
    run("post20", 1'b0, 32'h20, 32'h0, 2'd3, rd);
    chk("post20_const", rd, 32'hB1B2B3B4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
